// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy engine, the data memory and the
// top-level memory-side mux.
package mem_copy_pkg;

    localparam int MC_AW = 8;
    localparam int MC_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte-block copy engine driving the single-port data memory.
// Each byte costs one read cycle and one write cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for Start; memory outputs parked at 0
// ST_READ  | MemAddr = source pointer, data latched at the clock edge
// ST_WRITE | MemAddr = destination pointer, latched byte written
// ST_DONE  | one-cycle Done pulse, Busy still high
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int AW = MC_AW,
    parameter int DW = MC_DW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [AW-1:0] Len,
    input  logic          Descending,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    output logic          MemWrite,
    input  logic [DW-1:0] MemRData,
    output logic          Busy,
    output logic          Done
);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_src_ptr;
    logic [AW-1:0] r_dst_ptr;
    logic [AW-1:0] r_count;
    logic [DW-1:0] r_data;
    logic          r_desc;
    logic [AW-1:0] w_step;
    logic          w_last;

    // Adding all-ones is a decrement mod 2**AW, so one adder serves both directions.
    assign w_step = r_desc ? '1 : AW'(1);
    assign w_last = (r_count == AW'(1));

    // State register; reset parks the FSM in IDLE immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; Start is only looked at in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (Start) w_next_state = (Len == '0) ? ST_DONE : ST_READ;
            ST_READ:  w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = w_last ? ST_DONE : ST_READ;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Pointer, counter and data latch; request inputs are captured once at the Start edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_count   <= '0;
            r_data    <= '0;
            r_desc    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_desc  <= Descending;
                        r_count <= Len;
                        if (Descending) begin
                            // Start from the top byte so an upward-overlapping copy is safe.
                            r_src_ptr <= SrcAddr + Len - AW'(1);
                            r_dst_ptr <= DstAddr + Len - AW'(1);
                        end else begin
                            r_src_ptr <= SrcAddr;
                            r_dst_ptr <= DstAddr;
                        end
                    end
                end
                ST_READ: begin
                    r_data <= MemRData;
                end
                ST_WRITE: begin
                    r_src_ptr <= r_src_ptr + w_step;
                    r_dst_ptr <= r_dst_ptr + w_step;
                    r_count   <= r_count - AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Memory-side outputs decoded from state only, so Reset drops MemWrite at once.
    always_comb begin
        MemAddr  = '0;
        MemWData = '0;
        MemWrite = 1'b0;
        case (r_state)
            ST_READ: begin
                MemAddr = r_src_ptr;
            end
            ST_WRITE: begin
                MemAddr  = r_dst_ptr;
                MemWData = r_data;
                MemWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign Busy = (r_state != ST_IDLE);
    assign Done = (r_state == ST_DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a behavioural memory responds to the engine,
// and an independent byte-array model computes the expected memory image.
module tb_mem_copy_engine;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic [AW-1:0] SrcAddr;
    logic [AW-1:0] DstAddr;
    logic [AW-1:0] Len;
    logic          Descending;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic          MemWrite;
    logic [DW-1:0] MemRData;
    logic          Busy;
    logic          Done;

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] exp_mem [0:255];
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_copy_engine #(.AW(AW), .DW(DW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Len        (Len),
        .Descending (Descending),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemWrite   (MemWrite),
        .MemRData   (MemRData),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single-port data memory: combinational read, write at posedge.
    assign MemRData = mem[MemAddr];
    always @(posedge Clk) begin
        if (MemWrite) mem[MemAddr] <= MemWData;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] data);
        @(negedge Clk);
        tb_we   = 1'b1;
        tb_addr = addr;
        tb_data = data;
        exp_mem[addr] = data;
        @(posedge Clk);
        #1 tb_we = 1'b0;
    endtask

    // Reference: byte-by-byte copy in the chosen order over a mod-256 address space.
    task automatic model_copy(input int src, input int dst, input int len, input bit desc);
        for (int i = 0; i < len; i++) begin
            int j;
            j = desc ? (len - 1 - i) : i;
            exp_mem[(dst + j) & 255] = exp_mem[(src + j) & 255];
        end
    endtask

    task automatic compare_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                            input bit desc, input bit mid_start, input bit done_start,
                            input string tag);
        int busy_cnt, wr_cnt, consec, done_cnt, done_at, lat;
        bit prev_wr;
        busy_cnt = 0; wr_cnt = 0; consec = 0; done_cnt = 0; done_at = 0; prev_wr = 0;
        lat = 2 * int'(len) + 1;
        @(negedge Clk);
        SrcAddr = src; DstAddr = dst; Len = len; Descending = desc; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        SrcAddr = 8'($urandom); DstAddr = 8'($urandom);
        Len = 8'($urandom); Descending = 1'($urandom);
        model_copy(int'(src), int'(dst), int'(len), desc);
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge Clk);
            if (Busy) busy_cnt++;
            if (MemWrite) begin
                wr_cnt++;
                if (prev_wr) consec++;
            end
            prev_wr = MemWrite;
            if (Done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (mid_start && k == 3) Start = 1'b1;
            else if (done_start && Done) Start = 1'b1;
            else Start = 1'b0;
        end
        Start = 1'b0;
        check({tag, ".done_lat"}, done_at, lat);
        check({tag, ".done_cnt"}, done_cnt, 1);
        check({tag, ".busy_cyc"}, busy_cnt, lat);
        check({tag, ".writes"}, wr_cnt, int'(len));
        check({tag, ".consec_wr"}, consec, 0);
        compare_mem({tag, ".mem"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat[4];
        int dcnt, bcnt;
        Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0; Descending = 1'b0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        repeat (2) @(negedge Clk);
        check("rst.MemAddr", MemAddr, 0);
        check("rst.MemWData", MemWData, 0);
        check("rst.MemWrite", MemWrite, 0);
        check("rst.Busy", Busy, 0);
        check("rst.Done", Done, 0);
        Reset = 1'b0;

        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

        // Basic ascending copy
        pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), pat[i]);
        run_copy(8'h10, 8'h40, 8'd4, 1'b0, 1'b0, 1'b0, "asc4");
        for (int i = 0; i < 4; i++) check("asc4.byte", mem[8'h40 + i], pat[i]);

        // Zero length
        run_copy(8'($urandom), 8'($urandom), 8'd0, 1'b0, 1'b0, 1'b0, "len0");

        // Address wrap
        poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
        run_copy(8'hFE, 8'h80, 8'd3, 1'b0, 1'b0, 1'b0, "wrap");
        pat = '{8'h11, 8'h22, 8'h33, 8'h00};
        for (int i = 0; i < 3; i++) check("wrap.byte", mem[8'h80 + i], pat[i]);

        // Overlap, descending then ascending
        for (int i = 0; i < 4; i++) poke(8'(8'h20 + i), 8'(i + 1));
        run_copy(8'h20, 8'h22, 8'd4, 1'b1, 1'b0, 1'b0, "ovl_desc");
        pat = '{8'd1, 8'd2, 8'd3, 8'd4};
        for (int i = 0; i < 4; i++) check("ovl_desc.byte", mem[8'h22 + i], pat[i]);
        for (int i = 0; i < 4; i++) poke(8'(8'h20 + i), 8'(i + 1));
        run_copy(8'h20, 8'h22, 8'd4, 1'b0, 1'b0, 1'b0, "ovl_asc");
        pat = '{8'd1, 8'd2, 8'd1, 8'd2};
        for (int i = 0; i < 4; i++) check("ovl_asc.byte", mem[8'h22 + i], pat[i]);

        // Start pulses while busy and in the DONE cycle are ignored
        run_copy(8'h30, 8'h90, 8'd5, 1'b0, 1'b1, 1'b1, "start_busy");

        // Reset during the write of byte 2
        for (int i = 0; i < 4; i++) poke(8'(8'h50 + i), 8'(8'h60 + i));
        for (int i = 0; i < 4; i++) poke(8'(8'hA0 + i), 8'(8'hF0 + i));
        @(negedge Clk);
        SrcAddr = 8'h50; DstAddr = 8'hA0; Len = 8'd4; Descending = 1'b0; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (4) @(negedge Clk);
        check("rstmid.pre_write", MemWrite, 1);
        Reset = 1'b1;
        #1;
        check("rstmid.MemWrite", MemWrite, 0);
        check("rstmid.Busy", Busy, 0);
        check("rstmid.Done", Done, 0);
        @(negedge Clk);
        Reset = 1'b0;
        model_copy(32'h50, 32'hA0, 1, 1'b0);
        dcnt = 0; bcnt = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Done) dcnt++;
            if (Busy) bcnt++;
        end
        check("rstmid.no_done", dcnt, 0);
        check("rstmid.idle", bcnt, 0);
        check("rstmid.byte1", mem[8'hA0], 8'h60);
        check("rstmid.byte2", mem[8'hA1], 8'hF1);
        compare_mem("rstmid.mem");

        // Randomized transfers
        for (int t = 0; t < 20; t++) begin
            logic [7:0] l;
            l = 8'($urandom_range(0, 40));
            run_copy(8'($urandom), 8'($urandom), l, 1'($urandom),
                     (l >= 2) ? 1'($urandom) : 1'b0, 1'($urandom), "rand");
        end
        run_copy(8'($urandom), 8'($urandom), 8'd255, 1'($urandom), 1'b1, 1'b0, "rand_max");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
